// File: rtl/audio_stream_buffer.sv
// Audio stream buffer: playback and capture FIFOs around
// a four-state codec exchange sequencer.
module audio_stream_buffer #(
  parameter int SAMPLE_W      = 24,
  parameter int DEPTH         = 16,
  parameter bit UNDERRUN_ZERO = 1'b0,
  parameter bit MONO          = 1'b0
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SAMPLE_W-1:0]     s_left,
  input  logic [SAMPLE_W-1:0]     s_right,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [SAMPLE_W-1:0]     m_left,
  output logic [SAMPLE_W-1:0]     m_right,
  input  logic                    codec_write_ready,
  input  logic                    codec_read_ready,
  output logic                    codec_write,
  output logic                    codec_read,
  output logic [23:0]             codec_dac_left,
  output logic [23:0]             codec_dac_right,
  input  logic [23:0]             codec_adc_left,
  input  logic [23:0]             codec_adc_right,
  output logic                    underrun,
  output logic                    overrun,
  output logic [$clog2(DEPTH):0]  tx_level,
  output logic [$clog2(DEPTH):0]  rx_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    FIRE,
    HOLD
  } state_t;

  state_t state_q, state_d;

  logic [SAMPLE_W-1:0] tx_mem_l [DEPTH];
  logic [SAMPLE_W-1:0] tx_mem_r [DEPTH];
  logic [SAMPLE_W-1:0] rx_mem_l [DEPTH];
  logic [SAMPLE_W-1:0] rx_mem_r [DEPTH];

  logic [AW-1:0] tx_wp, tx_rp;
  logic [AW-1:0] rx_wp, rx_rp;
  logic [LW-1:0] tx_cnt, rx_cnt;

  logic tx_push, tx_pop;
  logic rx_push, rx_pop;
  logic rx_full, fire, armed, ovr;

  logic [23:0] head_l, head_r;
  logic [23:0] dac_l, dac_r;
  logic [23:0] last_l, last_r;

  // Left-justify a user sample into the 24-bit codec word.
  function automatic logic [23:0] pad(
    input logic [SAMPLE_W-1:0] s
  );
    pad = '0;
    pad[23 -: SAMPLE_W] = s;
  endfunction

  // Occupancy step: simultaneous push and pop cancel.
  function automatic logic [LW-1:0] step(
    input logic [LW-1:0] c,
    input logic          up,
    input logic          dn
  );
    unique case (1'b1)
      up & ~dn: step = c + 1'b1;
      dn & ~up: step = c - 1'b1;
      default:  step = c;
    endcase
  endfunction

  assign fire    = (state_q == FIRE);
  assign s_ready = (tx_cnt < FULL);
  assign tx_push = s_valid & s_ready;
  assign tx_pop  = fire & armed;
  assign rx_full = (rx_cnt == FULL);
  assign rx_pop  = (rx_cnt != '0) & m_ready;
  assign rx_push = fire & (~rx_full | rx_pop);
  assign ovr     = fire & rx_full & ~rx_pop;

  assign head_l = pad(tx_mem_l[tx_rp]);
  assign head_r = MONO ? head_l : pad(tx_mem_r[tx_rp]);

  // Sample storage writes; the RX side keeps the ADC MSBs.
  always_ff @(posedge CLOCK_50) begin
    if (!reset && tx_push) begin
      tx_mem_l[tx_wp] <= s_left;
      tx_mem_r[tx_wp] <= s_right;
    end
    if (!reset && rx_push) begin
      rx_mem_l[rx_wp] <= codec_adc_left[23 -: SAMPLE_W];
      rx_mem_r[rx_wp] <= codec_adc_right[23 -: SAMPLE_W];
    end
  end

  // Wrapping pointers and registered levels for both FIFOs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      tx_cnt <= step(tx_cnt, tx_push, tx_pop);
      rx_cnt <= step(rx_cnt, rx_push, rx_pop);
    end
  end

  // Codec data is loaded only in ARM and held otherwise.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      armed  <= 1'b0;
      dac_l  <= '0;
      dac_r  <= '0;
      last_l <= '0;
      last_r <= '0;
    end else if (state_q == ARM) begin
      armed <= (tx_cnt != '0);
      if (tx_cnt != '0) begin
        dac_l  <= head_l;
        dac_r  <= head_r;
        last_l <= head_l;
        last_r <= head_r;
      end else if (UNDERRUN_ZERO) begin
        dac_l <= '0;
        dac_r <= '0;
      end else begin
        dac_l <= last_l;
        dac_r <= last_r;
      end
    end
  end

  // Exchange sequencer state register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Exchange sequencer next state; ARM always completes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (codec_write_ready && codec_read_ready)
          state_d = ARM;
      end
      ARM:     state_d = FIRE;
      FIRE:    state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m_valid         = ~reset & (rx_cnt != '0);
  assign m_left          = reset ? '0 : rx_mem_l[rx_rp];
  assign m_right         = reset ? '0 : rx_mem_r[rx_rp];
  assign codec_write     = ~reset & fire;
  assign codec_read      = ~reset & fire;
  assign codec_dac_left  = reset ? '0 : dac_l;
  assign codec_dac_right = reset ? '0 : dac_r;
  assign underrun        = ~reset & fire & ~armed;
  assign overrun         = ~reset & ovr;
  assign tx_level        = reset ? '0 : tx_cnt;
  assign rx_level        = reset ? '0 : rx_cnt;

endmodule

// File: tb/tb_audio_stream_buffer.sv
// Scoreboard bench: stimulus queues expected exchanges and
// captures; monitors compare on FIRE and on RX handshakes.
module tb_audio_stream_buffer;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
    logic        und;
    logic        ovr;
  } fire_t;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
  } cap_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic        a_s_valid, a_s_ready, a_m_valid, a_m_ready;
  logic [23:0] a_s_left, a_s_right, a_m_left, a_m_right;
  logic        a_rdy, a_cw, a_cr, a_und, a_ovr;
  logic [23:0] a_dac_l, a_dac_r, a_adc_l, a_adc_r;
  logic [2:0]  a_txl, a_rxl;

  logic        b_s_valid, b_s_ready, b_m_valid, b_m_ready;
  logic [15:0] b_s_left, b_s_right, b_m_left, b_m_right;
  logic        b_rdy, b_cw, b_cr, b_und, b_ovr;
  logic [23:0] b_dac_l, b_dac_r, b_adc_l, b_adc_r;
  logic [2:0]  b_txl, b_rxl;

  audio_stream_buffer #(
    .SAMPLE_W(24), .DEPTH(4),
    .UNDERRUN_ZERO(1'b0), .MONO(1'b0)
  ) dut_a (
    .CLOCK_50(clk), .reset(reset),
    .s_valid(a_s_valid), .s_ready(a_s_ready),
    .s_left(a_s_left), .s_right(a_s_right),
    .m_valid(a_m_valid), .m_ready(a_m_ready),
    .m_left(a_m_left), .m_right(a_m_right),
    .codec_write_ready(a_rdy), .codec_read_ready(a_rdy),
    .codec_write(a_cw), .codec_read(a_cr),
    .codec_dac_left(a_dac_l), .codec_dac_right(a_dac_r),
    .codec_adc_left(a_adc_l), .codec_adc_right(a_adc_r),
    .underrun(a_und), .overrun(a_ovr),
    .tx_level(a_txl), .rx_level(a_rxl)
  );

  audio_stream_buffer #(
    .SAMPLE_W(16), .DEPTH(4),
    .UNDERRUN_ZERO(1'b1), .MONO(1'b1)
  ) dut_b (
    .CLOCK_50(clk), .reset(reset),
    .s_valid(b_s_valid), .s_ready(b_s_ready),
    .s_left(b_s_left), .s_right(b_s_right),
    .m_valid(b_m_valid), .m_ready(b_m_ready),
    .m_left(b_m_left), .m_right(b_m_right),
    .codec_write_ready(b_rdy), .codec_read_ready(b_rdy),
    .codec_write(b_cw), .codec_read(b_cr),
    .codec_dac_left(b_dac_l), .codec_dac_right(b_dac_r),
    .codec_adc_left(b_adc_l), .codec_adc_right(b_adc_r),
    .underrun(b_und), .overrun(b_ovr),
    .tx_level(b_txl), .rx_level(b_rxl)
  );

  fire_t qa[$], qb[$];
  cap_t  ra[$], rb[$];
  fire_t ea, eb;
  cap_t  ca, cb;
  int    fa = 0, fb = 0;
  int    fa_cyc[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic fire_t mkf(input logic [23:0] l,
                                input logic [23:0] r,
                                input logic u, input logic o);
    fire_t f;
    f.l = l; f.r = r; f.und = u; f.ovr = o;
    return f;
  endfunction

  function automatic cap_t mkc(input logic [23:0] l,
                               input logic [23:0] r);
    cap_t c;
    c.l = l; c.r = r;
    return c;
  endfunction

  // Monitor for instance A.
  always @(negedge clk) begin
    if (a_cw) begin
      fa++;
      fa_cyc.push_back(cyc);
      chk("a_read_strobe", {31'b0, a_cr}, 32'd1);
      if (qa.size() == 0) begin
        vectors++; errors++;
        $display("FAIL a_fire: got unexpected FIRE want none");
      end else begin
        ea = qa.pop_front();
        chk("a_dac_left", a_dac_l, ea.l);
        chk("a_dac_right", a_dac_r, ea.r);
        chk("a_underrun", {31'b0, a_und}, {31'b0, ea.und});
        chk("a_overrun", {31'b0, a_ovr}, {31'b0, ea.ovr});
      end
    end else begin
      chk("a_read_idle", {31'b0, a_cr}, 32'd0);
      chk("a_underrun_idle", {31'b0, a_und}, 32'd0);
      chk("a_overrun_idle", {31'b0, a_ovr}, 32'd0);
    end
    if (a_m_valid && a_m_ready) begin
      if (ra.size() == 0) begin
        vectors++; errors++;
        $display("FAIL a_capture: got unexpected m_valid want none");
      end else begin
        ca = ra.pop_front();
        chk("a_m_left", a_m_left, ca.l);
        chk("a_m_right", a_m_right, ca.r);
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (b_cw) begin
      fb++;
      if (qb.size() == 0) begin
        vectors++; errors++;
        $display("FAIL b_fire: got unexpected FIRE want none");
      end else begin
        eb = qb.pop_front();
        chk("b_dac_left", b_dac_l, eb.l);
        chk("b_dac_right", b_dac_r, eb.r);
        chk("b_underrun", {31'b0, b_und}, {31'b0, eb.und});
        chk("b_overrun", {31'b0, b_ovr}, {31'b0, eb.ovr});
      end
    end else begin
      chk("b_underrun_idle", {31'b0, b_und}, 32'd0);
    end
    if (b_m_valid && b_m_ready) begin
      if (rb.size() == 0) begin
        vectors++; errors++;
        $display("FAIL b_capture: got unexpected m_valid want none");
      end else begin
        cb = rb.pop_front();
        chk("b_m_left", {16'b0, b_m_left}, cb.l);
        chk("b_m_right", {16'b0, b_m_right}, cb.r);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [23:0] l,
                        input logic [23:0] r);
    int k;
    a_s_left = l; a_s_right = r; a_s_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!a_s_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!a_s_ready) begin
      vectors++; errors++;
      $display("FAIL a_push: got s_ready=0 want 1");
    end
    @(posedge clk);
    #1;
    a_s_valid = 1'b0;
  endtask

  task automatic push_b(input logic [15:0] l,
                        input logic [15:0] r);
    int k;
    b_s_left = l; b_s_right = r; b_s_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!b_s_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!b_s_ready) begin
      vectors++; errors++;
      $display("FAIL b_push: got s_ready=0 want 1");
    end
    @(posedge clk);
    #1;
    b_s_valid = 1'b0;
  endtask

  // Raise the codec ready flags until n more FIREs are seen.
  task automatic exch(input bit sel, input int n);
    int tgt, k, got;
    tgt = (sel ? fb : fa) + n;
    if (sel) b_rdy = 1'b1;
    else     a_rdy = 1'b1;
    k = 0;
    while ((sel ? fb : fa) < tgt && k < 20 * n) begin
      @(posedge clk);
      k++;
    end
    #1;
    got = sel ? fb : fa;
    chk(sel ? "b_exchange_count" : "a_exchange_count",
        got, tgt);
    if (sel) b_rdy = 1'b0;
    else     a_rdy = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int c0, base;
    reset = 1'b1;
    a_s_valid = 0; a_s_left = 0; a_s_right = 0;
    a_m_ready = 0; a_rdy = 0; a_adc_l = 0; a_adc_r = 0;
    b_s_valid = 0; b_s_left = 0; b_s_right = 0;
    b_m_ready = 0; b_rdy = 0; b_adc_l = 0; b_adc_r = 0;

    @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", {31'b0, a_s_ready}, 32'd1);
    chk("rst_m_valid", {31'b0, a_m_valid}, 32'd0);
    chk("rst_write", {31'b0, a_cw}, 32'd0);
    chk("rst_dac_left", a_dac_l, 24'd0);
    chk("rst_tx_level", {29'b0, a_txl}, 32'd0);
    chk("rst_rx_level", {29'b0, a_rxl}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Basic exchange
    a_m_ready = 1'b1;
    a_adc_l = 24'hA00000; a_adc_r = 24'h00000B;
    for (int i = 0; i < 3; i++) begin
      qa.push_back(mkf(24'h100000 + 24'(i), 24'(i), 0, 0));
      ra.push_back(mkc(24'hA00000, 24'h00000B));
      push_a(24'h100000 + 24'(i), 24'(i));
    end
    @(negedge clk);
    chk("basic_tx_level3", {29'b0, a_txl}, 32'd3);
    tick();
    base = fa_cyc.size();
    exch(0, 3);
    chk("basic_gap01", fa_cyc[base+1] - fa_cyc[base], 32'd4);
    chk("basic_gap12", fa_cyc[base+2] - fa_cyc[base+1], 32'd4);
    @(negedge clk);
    chk("basic_tx_level0", {29'b0, a_txl}, 32'd0);
    chk("basic_rx_level0", {29'b0, a_rxl}, 32'd0);
    tick();

    // Underrun repeats the last sent sample
    qa.push_back(mkf(24'h123456, 24'h654321, 0, 0));
    ra.push_back(mkc(24'hA00000, 24'h00000B));
    push_a(24'h123456, 24'h654321);
    exch(0, 1);
    for (int i = 0; i < 2; i++) begin
      qa.push_back(mkf(24'h123456, 24'h654321, 1, 0));
      ra.push_back(mkc(24'hA00000, 24'h00000B));
    end
    exch(0, 2);

    // Overrun: DEPTH+1 exchanges with capture stalled
    a_m_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      a_adc_l = 24'h110000 * 24'(k);
      a_adc_r = 24'(k);
      qa.push_back(mkf(24'h123456, 24'h654321, 1, k == 5));
      if (k <= 4)
        ra.push_back(mkc(24'h110000 * 24'(k), 24'(k)));
      exch(0, 1);
    end
    @(negedge clk);
    chk("ovr_rx_level", {29'b0, a_rxl}, 32'd4);
    chk("ovr_head_left", a_m_left, 24'h110000);
    tick();

    // Full RX with pop in the FIRE cycle still captures
    a_adc_l = 24'h5A5A5A; a_adc_r = 24'hA5A5A5;
    qa.push_back(mkf(24'h123456, 24'h654321, 1, 0));
    ra.push_back(mkc(24'h5A5A5A, 24'hA5A5A5));
    a_rdy = 1'b1;
    tick();
    tick();
    a_m_ready = 1'b1;
    a_rdy = 1'b0;
    tick();
    a_m_ready = 1'b0;
    @(negedge clk);
    chk("full_pop_rx_level", {29'b0, a_rxl}, 32'd4);
    tick();
    a_m_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("drain_rx_level", {29'b0, a_rxl}, 32'd0);
    chk("drain_queue", ra.size(), 32'd0);

    // Full TX
    for (int i = 0; i < 4; i++) begin
      qa.push_back(mkf(24'h200000 + 24'(i), 24'h300 + 24'(i), 0, 0));
      push_a(24'h200000 + 24'(i), 24'h300 + 24'(i));
    end
    @(negedge clk);
    chk("full_s_ready", {31'b0, a_s_ready}, 32'd0);
    chk("full_tx_level", {29'b0, a_txl}, 32'd4);
    tick();
    a_s_left = 24'hDEAD00; a_s_valid = 1'b1;
    tick();
    a_s_valid = 1'b0;
    @(negedge clk);
    chk("blocked_tx_level", {29'b0, a_txl}, 32'd4);
    tick();
    a_adc_l = 24'h777777; a_adc_r = 24'h888888;
    for (int i = 0; i < 16; i++)
      ra.push_back(mkc(24'h777777, 24'h888888));
    exch(0, 1);
    @(negedge clk);
    chk("after_pop_s_ready", {31'b0, a_s_ready}, 32'd1);
    chk("after_pop_tx_level", {29'b0, a_txl}, 32'd3);
    tick();

    // Pointer wrap: 3*DEPTH streamed samples
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          qa.push_back(mkf(24'h400000 + 24'(i),
                           24'h500000 + 24'(i), 0, 0));
          push_a(24'h400000 + 24'(i), 24'h500000 + 24'(i));
        end
      end
      begin
        exch(0, 15);
      end
    join
    @(negedge clk);
    chk("stream_tx_level", {29'b0, a_txl}, 32'd0);
    chk("stream_queue", qa.size(), 32'd0);
    chk("stream_rx_queue", ra.size(), 32'd0);
    tick();

    // Mid-operation reset in FIRE
    a_m_ready = 1'b0;
    push_a(24'h0F0000, 24'h0F0001);
    push_a(24'h0E0000, 24'h0E0001);
    a_rdy = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mrst_write", {31'b0, a_cw}, 32'd0);
    chk("mrst_tx_level", {29'b0, a_txl}, 32'd0);
    chk("mrst_rx_level", {29'b0, a_rxl}, 32'd0);
    chk("mrst_underrun", {31'b0, a_und}, 32'd0);
    c0 = cyc;
    qa.push_back(mkf(24'h0, 24'h0, 1, 0));
    a_m_ready = 1'b1;
    ra.push_back(mkc(24'h777777, 24'h888888));
    exch(0, 1);
    chk("mrst_first_fire", fa_cyc[fa_cyc.size()-1] - c0, 32'd2);

    // Width conversion, mono, zero underrun on instance B
    b_m_ready = 1'b1;
    b_adc_l = 24'h89AB12; b_adc_r = 24'h456789;
    qb.push_back(mkf(24'hABCD00, 24'hABCD00, 0, 0));
    rb.push_back(mkc(24'h0089AB, 24'h004567));
    push_b(16'hABCD, 16'h1234);
    exch(1, 1);
    b_adc_l = 24'hFEDCBA; b_adc_r = 24'h0F0F0F;
    qb.push_back(mkf(24'h0, 24'h0, 1, 0));
    rb.push_back(mkc(24'h00FEDC, 24'h000F0F));
    exch(1, 1);
    qb.push_back(mkf(24'h111100, 24'h111100, 0, 0));
    rb.push_back(mkc(24'h00FEDC, 24'h000F0F));
    push_b(16'h1111, 16'h2222);
    exch(1, 1);
    @(negedge clk);
    chk("b_tx_level", {29'b0, b_txl}, 32'd0);
    chk("b_rx_level", {29'b0, b_rxl}, 32'd0);
    tick();

    for (int k = 0; k < 4; k++) tick();
    chk("end_qa", qa.size(), 32'd0);
    chk("end_qb", qb.size(), 32'd0);
    chk("end_ra", ra.size(), 32'd0);
    chk("end_rb", rb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
